// File: rtl/latency_ram.sv
// Word-addressed RAM with a fixed BUSY latency before each access.
// Requests must stay stable while BUSY; any change aborts the access.
package latency_ram_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module latency_ram
    import latency_ram_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 256
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output ramstate_t   ramstate
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT =
        (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    ramstate_t   state, nxt;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] laddr, ldata;
    logic        lwen;
    logic [31:0] mem [DEPTH];

    logic          any_en, valid, illegal, same;
    logic          latch, acc;
    logic [AW-1:0] aidx;
    logic          awen;
    logic [31:0]   adata;

    assign any_en  = ramREN | ramWEN;
    assign valid   = (ramREN ^ ramWEN)
                   && (ramaddr[1:0] == 2'b00)
                   && (ramaddr[31:2] < 30'(DEPTH));
    assign illegal = any_en & ~valid;
    assign same    = (ramaddr == laddr)
                   && (ramWEN == lwen)
                   && (ramstore == ldata);

    // From FREE (LAT==0) the latches are not loaded yet; use the inputs.
    assign aidx  = (state == FREE) ? ramaddr[AW+1:2] : laddr[AW+1:2];
    assign awen  = (state == FREE) ? ramWEN : lwen;
    assign adata = (state == FREE) ? ramstore : ldata;

    assign ramstate = state;

    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        latch = 1'b0;
        acc   = 1'b0;
        unique case (state)
            FREE: begin
                if (valid) begin
                    latch = 1'b1;
                    if (LAT > 0) begin
                        nxt   = BUSY;
                        cnt_n = CNT_INIT;
                    end else begin
                        nxt = ACCESS;
                        acc = 1'b1;
                    end
                end else if (illegal) begin
                    nxt = ERROR;
                end
            end
            BUSY: begin
                if (valid && same) begin
                    if (cnt != 4'd0) begin
                        cnt_n = cnt - 4'd1;
                    end else begin
                        nxt = ACCESS;
                        acc = 1'b1;
                    end
                end else begin
                    nxt   = FREE;
                    cnt_n = 4'd0;
                end
            end
            ACCESS: begin
                nxt   = FREE;
                cnt_n = 4'd0;
            end
            ERROR: begin
                if (!any_en) nxt = FREE;
            end
            default: nxt = FREE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= FREE;
            cnt     <= 4'd0;
            laddr   <= 32'd0;
            ldata   <= 32'd0;
            lwen    <= 1'b0;
            ramload <= 32'd0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
            if (latch) begin
                laddr <= ramaddr;
                ldata <= ramstore;
                lwen  <= ramWEN;
            end
            if (acc && !awen) ramload <= mem[aidx];
        end
    end

    // Storage is never reset; gate on nRST so no write lands during reset.
    always_ff @(posedge CLK) begin
        if (nRST && acc && awen) mem[aidx] <= adata;
    end

endmodule

// File: tb/tb_latency_ram.sv
// Directed bench for latency_ram: LAT=2 and LAT=0 instances.
// Expected values are hand-computed constants.
module tb_latency_ram;
    import latency_ram_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [31:0] addr = 32'd0, store = 32'd0;
    logic [31:0] load;
    ramstate_t   st;
    logic        ren0 = 1'b0, wen0 = 1'b0;
    logic [31:0] addr0 = 32'd0, store0 = 32'd0;
    logic [31:0] load0;
    ramstate_t   st0;

    int npass = 0;
    int ntot  = 0;

    latency_ram #(.LAT(2), .DEPTH(256)) dut (
        .CLK(CLK), .nRST(nRST),
        .ramREN(ren), .ramWEN(wen),
        .ramaddr(addr), .ramstore(store),
        .ramload(load), .ramstate(st)
    );

    latency_ram #(.LAT(0), .DEPTH(256)) dut0 (
        .CLK(CLK), .nRST(nRST),
        .ramREN(ren0), .ramWEN(wen0),
        .ramaddr(addr0), .ramstore(store0),
        .ramload(load0), .ramstate(st0)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; store = d;
        chk("wr_free", 32'(st), 32'(FREE));
        step(); chk("wr_busy1", 32'(st), 32'(BUSY));
        step(); chk("wr_busy2", 32'(st), 32'(BUSY));
        step(); chk("wr_acc", 32'(st), 32'(ACCESS));
        wen = 1'b0;
        step(); chk("wr_done", 32'(st), 32'(FREE));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        ren = 1'b1; addr = a;
        chk("rd_free", 32'(st), 32'(FREE));
        step(); chk("rd_busy1", 32'(st), 32'(BUSY));
        step(); chk("rd_busy2", 32'(st), 32'(BUSY));
        step(); chk("rd_acc", 32'(st), 32'(ACCESS));
        chk("rd_data", load, e);
        ren = 1'b0;
        step(); chk("rd_done", 32'(st), 32'(FREE));
        chk("rd_hold", load, e);
    endtask

    task automatic bad_wr(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; store = d;
        step(); chk("bad_err", 32'(st), 32'(ERROR));
        wen = 1'b0;
        step(); chk("bad_free", 32'(st), 32'(FREE));
    endtask

    initial begin
        #12;
        chk("rst_state", 32'(st), 32'(FREE));
        chk("rst_load", load, 32'd0);
        chk("rst_state0", 32'(st0), 32'(FREE));
        step();
        nRST = 1'b1;

        // write then read-after-write
        wr(32'h40, 32'hDEADBEEF);
        rd(32'h40, 32'hDEADBEEF);

        // both enables -> ERROR held while asserted
        wr(32'h10, 32'h11112222);
        ren = 1'b1; wen = 1'b1;
        addr = 32'h10; store = 32'hFFFFFFFF;
        chk("both_free", 32'(st), 32'(FREE));
        for (int i = 0; i < 3; i++) begin
            step(); chk("both_err", 32'(st), 32'(ERROR));
        end
        ren = 1'b0; wen = 1'b0;
        step(); chk("both_free2", 32'(st), 32'(FREE));
        rd(32'h10, 32'h11112222);

        // misaligned and out-of-range writes
        wr(32'h0, 32'h0BADF00D);
        bad_wr(32'h42, 32'h55555555);
        bad_wr(32'h400, 32'h66666666);
        rd(32'h40, 32'hDEADBEEF);
        rd(32'h0, 32'h0BADF00D);

        // last word in range
        wr(32'h3FC, 32'h3FC3FC3F);
        rd(32'h3FC, 32'h3FC3FC3F);

        // address change during BUSY aborts
        wr(32'h80, 32'h80808080);
        wr(32'h84, 32'h84848484);
        ren = 1'b1; addr = 32'h80;
        step(); chk("ab_busy", 32'(st), 32'(BUSY));
        addr = 32'h84;
        step(); chk("ab_free", 32'(st), 32'(FREE));
        rd(32'h84, 32'h84848484);

        // reset during a BUSY write drops it
        wr(32'h20, 32'hAAAA5555);
        rd(32'h20, 32'hAAAA5555);
        wen = 1'b1; addr = 32'h20; store = 32'h12345678;
        step(); chk("rw_busy", 32'(st), 32'(BUSY));
        #1 nRST = 1'b0;
        #1;
        chk("rw_state", 32'(st), 32'(FREE));
        chk("rw_load", load, 32'd0);
        wen = 1'b0;
        step();
        nRST = 1'b1;
        rd(32'h20, 32'hAAAA5555);
        rd(32'h40, 32'hDEADBEEF);

        // LAT=0 instance
        wen0 = 1'b1; addr0 = 32'h0; store0 = 32'hCAFE0001;
        chk("z_free", 32'(st0), 32'(FREE));
        step(); chk("z_wacc", 32'(st0), 32'(ACCESS));
        wen0 = 1'b0;
        step(); chk("z_wfree", 32'(st0), 32'(FREE));
        ren0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); chk("z_racc", 32'(st0), 32'(ACCESS));
            chk("z_rdata", load0, 32'hCAFE0001);
            step(); chk("z_rfree", 32'(st0), 32'(FREE));
        end
        ren0 = 1'b0;
        step(); chk("z_idle", 32'(st0), 32'(FREE));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want done");
        $fatal(1);
    end

endmodule

// File: doc/latency_ram.md
LATENCY_RAM -- requirements
Module: latency_ram

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning the number of BUSY cycles before ACCESS (legal range 0..15).
REQ-002 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words stored (power of two).
REQ-003 SHALL have port CLK, input, 1 bit, the clock; all state updates on the rising edge.
REQ-004 SHALL have port nRST, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 SHALL have port ramREN, input, 1 bit, the read request, held by the requester until ACCESS.
REQ-006 SHALL have port ramWEN, input, 1 bit, the write request, held by the requester until ACCESS.
REQ-007 SHALL have port ramaddr, input, 32 bits, the byte address; it must be word aligned.
REQ-008 SHALL have port ramstore, input, 32 bits, the write data.
REQ-009 SHALL have port ramload, output, 32 bits, the read data; it is valid while ramstate is ACCESS for a read.
REQ-010 SHALL have port ramstate, output, 2 bits (ramstate_t), the responder status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-011 SHALL drive ramstate directly from the state register, with no combinational path from the request inputs.
REQ-012 SHALL classify a request as valid when exactly one of ramREN/ramWEN is high, ramaddr[1:0]==0, and ramaddr[31:2] < DEPTH.
REQ-013 SHALL classify a request as illegal when both ramREN and ramWEN are high, or ramaddr is misaligned, or ramaddr[31:2] >= DEPTH with either enable high.
REQ-014 SHALL make these FREE transitions:
- valid request at an edge -> latch addr, op and data;
- LAT>0 -> BUSY with cnt=LAT-1;
- LAT==0 -> ACCESS directly;
- illegal request -> ERROR;
- no request -> stay FREE.
REQ-015 SHALL make these BUSY transitions:
- request still valid with addr/op/ramstore unchanged from the latched values and cnt>0 -> cnt decrements;
- same conditions with cnt==0 -> ACCESS;
- any change or drop of the request -> abort to FREE with no memory update.
REQ-016 SHALL perform memory writes only on the edge that enters ACCESS: mem[addr[31:2]] <= latched ramstore.
REQ-017 SHALL, for reads, register mem[addr[31:2]] into ramload on the edge that enters ACCESS, and hold ramload until the next ACCESS entry.
REQ-018 SHALL hold ACCESS for exactly one cycle, then return to FREE unconditionally; a request still held is then re-accepted as a new access.
REQ-019 SHALL stay in ERROR while any enable is high, return to FREE on the first edge with both enables low, and never modify memory in ERROR.
REQ-020 SHALL give a read-after-write to the same address, issued the cycle after the write's ACCESS, the new data.
REQ-021 SHALL set latency from request assertion to ACCESS at LAT+1 cycles (ramstate visible FREE during the first request cycle).
REQ-022 SHALL use a 4-bit cnt that never wraps; decrement occurs only when cnt>0.

Reset
REQ-023 SHALL, while nRST is low, force state=FREE, cnt=0, ramload=0 and clear the latched addr/op/data, independent of CLK.
REQ-024 SHALL NOT clear memory contents on reset; contents persist across reset.
REQ-025 SHALL NOT commit a write that is in BUSY when reset asserts.

Verification
REQ-026 SHALL cover write-then-read with LAT=2: WEN, addr 0x40, store 0xDEADBEEF -> ramstate FREE,BUSY,BUSY,ACCESS; then REN 0x40 -> ACCESS with ramload=0xDEADBEEF.
REQ-027 SHALL cover REN and WEN both high at addr 0x10 -> ERROR on the next cycle, held for 3 cycles; both dropped -> FREE; mem[4] unchanged.
REQ-028 SHALL cover WEN at addr 0x42 (misaligned) or 0x400 (out of range, DEPTH=256) -> ERROR, with no write observed by later reads.
REQ-029 SHALL cover REN at 0x80 with ramaddr changed to 0x84 during the first BUSY cycle -> FREE next cycle, then a fresh LAT+1 cycle access returning mem[0x84>>2].
REQ-030 SHALL cover nRST pulsed low during BUSY of a write of 0x12345678 to 0x20 (prior value 0xAAAA5555) -> FREE, ramload=0 immediately; a later read of 0x20 returns 0xAAAA5555.
REQ-031 SHALL cover LAT=0 with a held REN at 0x0 -> ramstate alternates ACCESS, FREE, ACCESS, and ramload equals mem[0] on each ACCESS.
